// File: rtl/score_display_ctrl.sv
// score_display_ctrl
//   Converts a binary score into four active-low 7-segment patterns (hex0 = units).
//   The conversion is sequential, using double-dabble (shift-add-3) over SCORE_W cycles.
//   A single external BCD-to-7-seg decoder is then time-shared over four scan cycles.
//   The four results are collected in a shadow bank and committed to the display in
//   one edge, so the display never shows a half-updated score.
module score_display_ctrl #(
  parameter int SCORE_W    = 14,
  parameter int SAT_VALUE  = 9999,
  parameter bit BLANK_LEAD = 1'b1
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic [SCORE_W-1:0] score_in,
  input  logic               load,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic [3:0]         dec_bcd,
  input  logic [0:6]         dec_ss,
  output logic [0:6]         hex0,
  output logic [0:6]         hex1,
  output logic [0:6]         hex2,
  output logic [0:6]         hex3
);

  localparam int BCD_W = 16;
  localparam int SR_W  = BCD_W + SCORE_W;
  localparam int CNT_W = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
  localparam logic [CNT_W-1:0]   LAST_STEP = CNT_W'(SCORE_W - 1);
  localparam logic [31:0]        SAT_U     = 32'(SAT_VALUE);
  localparam logic [SCORE_W-1:0] SAT_CLAMP = SCORE_W'(SAT_VALUE);
  localparam logic [0:6]         SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_SCAN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_reg, state_next;

  // Combined double-dabble register: BCD field on top, binary operand below.
  logic [SR_W-1:0]  sr_reg;
  logic [CNT_W-1:0] step_reg;
  logic [1:0]       digit_reg;
  logic             overflow_reg;
  logic [0:6]       shadow_reg [4];
  logic [0:6]       hex_reg    [4];

  // Load-side saturation
  logic [31:0]        score_wide;
  logic               over_sat;
  logic [SCORE_W-1:0] score_clamped;

  // Conversion step datapath
  logic [BCD_W-1:0] bcd_cur;
  logic [BCD_W-1:0] bcd_adj;
  logic [SR_W-1:0]  sr_adj;
  logic [SR_W-1:0]  sr_shift;

  // Scan datapath
  logic [3:0] blank_vec;
  logic [3:0] cur_nibble;
  logic       cur_blank;
  logic [0:6] seg_capture;

  assign score_wide    = 32'(score_in);
  assign over_sat      = (score_wide > SAT_U);
  assign score_clamped = over_sat ? SAT_CLAMP : score_in;

  assign bcd_cur = sr_reg[SR_W-1:SCORE_W];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      // Add-3 correction: any nibble >= 5 would exceed 9 after the doubling shift
      assign bcd_adj[gi*4 +: 4] = (bcd_cur[gi*4 +: 4] >= 4'd5) ? (bcd_cur[gi*4 +: 4] + 4'd3)
                                                               : bcd_cur[gi*4 +: 4];
      // Leading-zero blanking: a digit is blank when it and every higher digit are zero
      if (gi == 0) begin : g_units
        assign blank_vec[gi] = 1'b0;
      end else begin : g_upper
        assign blank_vec[gi] = BLANK_LEAD && (bcd_cur[BCD_W-1:gi*4] == '0);
      end
    end
  endgenerate

  assign sr_adj   = {bcd_adj, sr_reg[SCORE_W-1:0]};
  assign sr_shift = {sr_adj[SR_W-2:0], 1'b0};

  assign cur_nibble  = bcd_cur[{digit_reg, 2'b00} +: 4];
  assign cur_blank   = blank_vec[digit_reg];
  assign seg_capture = cur_blank ? SEG_BLANK : dec_ss;

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: a load is only seen in IDLE, so loads while busy are dropped
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (load) state_next = S_CONV;
      S_CONV: if (step_reg == LAST_STEP) state_next = S_SCAN;
      S_SCAN: if (digit_reg == 2'd3) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state only; dec_bcd follows the scan index
  always_comb begin
    busy    = (state_reg != S_IDLE);
    done    = (state_reg == S_DONE);
    dec_bcd = 4'd0;
    if (state_reg == S_SCAN) begin
      dec_bcd = cur_nibble;
    end
  end

  // Conversion datapath: capture on accepted load, then shift-add-3 once per CONV cycle
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sr_reg       <= '0;
      step_reg     <= '0;
      digit_reg    <= 2'd0;
      overflow_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (load) begin
            sr_reg       <= {{BCD_W{1'b0}}, score_clamped};
            step_reg     <= '0;
            digit_reg    <= 2'd0;
            overflow_reg <= over_sat;
          end
        end
        S_CONV: begin
          sr_reg    <= sr_shift;
          step_reg  <= step_reg + CNT_W'(1);
          digit_reg <= 2'd0;
        end
        S_SCAN: begin
          digit_reg <= digit_reg + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Scan capture into the shadow bank; the last scan edge commits all four digits at once
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 4; i++) begin
        shadow_reg[i] <= SEG_BLANK;
        hex_reg[i]    <= SEG_BLANK;
      end
    end else if (state_reg == S_SCAN) begin
      shadow_reg[digit_reg] <= seg_capture;
      if (digit_reg == 2'd3) begin
        hex_reg[0] <= shadow_reg[0];
        hex_reg[1] <= shadow_reg[1];
        hex_reg[2] <= shadow_reg[2];
        // digit 3 is being decoded this very edge, so it bypasses the shadow
        hex_reg[3] <= seg_capture;
      end
    end
  end

  assign overflow = overflow_reg;
  assign hex0     = hex_reg[0];
  assign hex1     = hex_reg[1];
  assign hex2     = hex_reg[2];
  assign hex3     = hex_reg[3];

endmodule

// File: tb/tb_score_display_ctrl.sv
// tb_score_display_ctrl
//   Directed plus random loads into two instances (leading-zero blanking on and off),
//   each with its own BCD-to-7-seg decoder model, checked against an arithmetic reference.
module tb_score_display_ctrl;

  localparam int SCORE_W = 14;
  localparam int LAT     = SCORE_W + 5;

  logic               clock    = 1'b0;
  logic               resetn   = 1'b0;
  logic               load     = 1'b0;
  logic [SCORE_W-1:0] score_in = '0;

  logic       busy_a, done_a, overflow_a;
  logic [3:0] dec_bcd_a;
  logic [0:6] dec_ss_a, hex0_a, hex1_a, hex2_a, hex3_a;

  logic       busy_b, done_b, overflow_b;
  logic [3:0] dec_bcd_b;
  logic [0:6] dec_ss_b, hex0_b, hex1_b, hex2_b, hex3_b;

  int errors     = 0;
  int checks     = 0;
  int done_total = 0;

  logic [0:6] cap_a [4];
  logic [0:6] cap_b [4];

  always #5 clock = ~clock;

  // 7-segment table, active-low, segment a leftmost
  function automatic logic [6:0] seg7(input int d);
    case (d)
      0: seg7 = 7'b0000001;
      1: seg7 = 7'b1001111;
      2: seg7 = 7'b0010010;
      3: seg7 = 7'b0000110;
      4: seg7 = 7'b1001100;
      5: seg7 = 7'b0100100;
      6: seg7 = 7'b0100000;
      7: seg7 = 7'b0001111;
      8: seg7 = 7'b0000000;
      9: seg7 = 7'b0001100;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // External decoders
  assign dec_ss_a = seg7(int'(dec_bcd_a));
  assign dec_ss_b = seg7(int'(dec_bcd_b));

  // Reference: expected pattern of one digit for a given raw score
  function automatic logic [6:0] ref_hex(input int score, input int digit, input bit blank_lead);
    int v;
    int p;
    v = (score > 9999) ? 9999 : score;
    p = 1;
    for (int k = 0; k < digit; k++) p = p * 10;
    if (blank_lead && digit > 0 && v < p) ref_hex = 7'b1111111;
    else ref_hex = seg7((v / p) % 10);
  endfunction

  score_display_ctrl #(.SCORE_W(SCORE_W), .SAT_VALUE(9999), .BLANK_LEAD(1'b1)) dut_a (
    .clock(clock), .resetn(resetn), .score_in(score_in), .load(load),
    .busy(busy_a), .done(done_a), .overflow(overflow_a),
    .dec_bcd(dec_bcd_a), .dec_ss(dec_ss_a),
    .hex0(hex0_a), .hex1(hex1_a), .hex2(hex2_a), .hex3(hex3_a)
  );

  score_display_ctrl #(.SCORE_W(SCORE_W), .SAT_VALUE(9999), .BLANK_LEAD(1'b0)) dut_b (
    .clock(clock), .resetn(resetn), .score_in(score_in), .load(load),
    .busy(busy_b), .done(done_b), .overflow(overflow_b),
    .dec_bcd(dec_bcd_b), .dec_ss(dec_ss_b),
    .hex0(hex0_b), .hex1(hex1_b), .hex2(hex2_b), .hex3(hex3_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // done must never be high on two consecutive cycles
  logic prev_done = 1'b0;
  always @(negedge clock) begin
    if (done_a) begin
      done_total++;
      checks++;
      assert (!prev_done) else begin
        errors++;
        $error("FAIL done_consecutive: observed=1 expected=0 at %0t", $time);
      end
    end
    prev_done = done_a;
  end

  // One load transaction; optionally hammer load with score 5 during busy cycles 3..10
  task automatic run_load(input int value, input bit junk);
    int n;
    int done_at;
    int dones;
    @(negedge clock);
    score_in = SCORE_W'(value);
    load     = 1'b1;
    @(negedge clock);
    load = 1'b0;
    n = 0;
    done_at = 0;
    dones = 0;
    while (busy_a && n < 40) begin
      n++;
      if (done_a) begin
        done_at = n;
        dones++;
        cap_a[0] = hex0_a; cap_a[1] = hex1_a; cap_a[2] = hex2_a; cap_a[3] = hex3_a;
        cap_b[0] = hex0_b; cap_b[1] = hex1_b; cap_b[2] = hex2_b; cap_b[3] = hex3_b;
      end
      if (junk) begin
        load     = (n >= 2 && n < 10);
        score_in = SCORE_W'(5);
      end
      @(negedge clock);
    end
    load = 1'b0;
    $display("load score=%0d busy_cycles=%0d done_at=%0d hex3..0=%b %b %b %b ovf=%0b",
             value, n, done_at, cap_a[3], cap_a[2], cap_a[1], cap_a[0], overflow_a);
    check("busy_cycles", 32'(n), 32'(LAT));
    check("done_cycle", 32'(done_at), 32'(LAT));
    check("done_count", 32'(dones), 32'd1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("hex%0d_blank_v%0d", k, value), 32'(cap_a[k]), 32'(ref_hex(value, k, 1'b1)));
      check($sformatf("hex%0d_full_v%0d", k, value), 32'(cap_b[k]), 32'(ref_hex(value, k, 1'b0)));
    end
    check("overflow", 32'(overflow_a), 32'(value > 9999));
    check("idle_dec_bcd", 32'(dec_bcd_a), 32'd0);
  endtask

  initial begin
    int d0;
    int v;

    // Reset state
    #12;
    check("rst_hex0", 32'(hex0_a), 32'h7f);
    check("rst_hex1", 32'(hex1_a), 32'h7f);
    check("rst_hex2", 32'(hex2_a), 32'h7f);
    check("rst_hex3", 32'(hex3_a), 32'h7f);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_overflow", 32'(overflow_a), 32'd0);
    check("rst_dec_bcd", 32'(dec_bcd_a), 32'd0);
    $display("reset hex3..0=%b %b %b %b busy=%0b", hex3_a, hex2_a, hex1_a, hex0_a, busy_a);
    @(negedge clock);
    resetn = 1'b1;

    // 1234 with literal digit patterns
    run_load(1234, 1'b0);
    check("lit_hex3", 32'(hex3_a), 32'(7'b1001111));
    check("lit_hex2", 32'(hex2_a), 32'(7'b0010010));
    check("lit_hex1", 32'(hex1_a), 32'(7'b0000110));
    check("lit_hex0", 32'(hex0_a), 32'(7'b1001100));

    // Zero: blanked vs full display
    run_load(0, 1'b0);
    check("zero_hex3_blank", 32'(hex3_a), 32'h7f);
    check("zero_hex0_blank", 32'(hex0_a), 32'(7'b0000001));
    check("zero_hex3_full", 32'(hex3_b), 32'(7'b0000001));

    // Saturation, then overflow clears on a legal load
    run_load(16383, 1'b0);
    check("sat_hex2", 32'(hex2_a), 32'(7'b0001100));
    run_load(7, 1'b0);
    check("seven_hex0", 32'(hex0_a), 32'(7'b0001111));
    check("seven_hex1", 32'(hex1_a), 32'h7f);

    // Loads during busy are ignored
    d0 = done_total;
    run_load(42, 1'b1);
    run_load(5, 1'b0);
    check("two_dones", 32'(done_total - d0), 32'd2);

    // Abort mid-conversion with reset; overflow set first so the clear is visible
    run_load(10000, 1'b0);
    @(negedge clock);
    score_in = SCORE_W'(1234);
    load     = 1'b1;
    @(negedge clock);
    load = 1'b0;
    repeat (5) @(negedge clock);
    d0 = done_total;
    resetn = 1'b0;
    #1;
    check("abort_hex0", 32'(hex0_a), 32'h7f);
    check("abort_hex3", 32'(hex3_a), 32'h7f);
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_overflow", 32'(overflow_a), 32'd0);
    check("abort_dec_bcd", 32'(dec_bcd_a), 32'd0);
    $display("abort hex3..0=%b %b %b %b busy=%0b", hex3_a, hex2_a, hex1_a, hex0_a, busy_a);
    @(negedge clock);
    resetn = 1'b1;
    repeat (3) @(negedge clock);
    check("abort_no_done", 32'(done_total - d0), 32'd0);
    check("abort_idle", 32'(busy_a), 32'd0);
    run_load(80, 1'b0);

    // Random loads, biased towards small values and the saturation boundary
    for (int r = 0; r < 25; r++) begin
      case ($urandom_range(0, 3))
        0: v = int'($urandom_range(0, 99));
        1: v = int'($urandom_range(9990, 10010));
        default: v = int'($urandom_range(0, 16383));
      endcase
      run_load(v, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
